everloop_fb_ctrl: RTL and testbench
===================================

EVERLOOP_FB_CTRL -- requirements
Module: everloop_fb_ctrl

Interface
REQ-001 SHALL have parameter FRAME_BYTES, default 141, meaning bytes per LED frame; the driver address reaches FRAME_BYTES during its reset phase.
REQ-002 SHALL have port clk, input, 1, single clock for all logic.
REQ-003 SHALL have port rst_n, input, 1, reset that is synchronous and active-low.
REQ-004 SHALL have ports wr_en / wr_addr / wr_data, input, 1/8/8, host byte write into the back bank.
REQ-005 SHALL have port wr_ready, output, 1, host writes accepted.
REQ-006 SHALL have port commit, input, 1, single-cycle request to swap the banks at the next frame boundary.
REQ-007 SHALL have port clear, input, 1, single-cycle request to zero-fill the back bank.
REQ-008 SHALL have port commit_done, output, 1, one-cycle pulse when a swap completes.
REQ-009 SHALL have port frame_tick, output, 1, one-cycle pulse on each frame boundary.
REQ-010 SHALL have port led_addr, input, 8, byte address from the LED serial driver.
REQ-011 SHALL have port led_data, output, 8, byte returned to the LED serial driver.

Function
REQ-012 SHALL hold two banks of FRAME_BYTES bytes each; register front_sel selects the bank the driver reads, and the host writes the other bank.
REQ-013 SHALL drive led_data combinationally, with zero latency, from front[led_addr]; led_addr >= FRAME_BYTES SHALL return 0.
REQ-014 SHALL define the frame boundary as the first cycle in which led_addr == FRAME_BYTES after a cycle with led_addr != FRAME_BYTES; frame_tick SHALL pulse in the following cycle.
REQ-015 SHALL implement FSM states IDLE, CLEAR, PENDING and SWAP.
REQ-016 In IDLE: wr_ready=1, and wr_en with wr_addr < FRAME_BYTES SHALL write back[wr_addr] at the clock edge; out-of-range writes SHALL be dropped.
REQ-017 In IDLE: clear -> CLEAR, with clr_cnt=0; otherwise commit -> PENDING; clear and commit together -> CLEAR, and the commit SHALL be ignored.
REQ-018 In CLEAR: wr_ready=0; each cycle writes back[clr_cnt]=0 and increments clr_cnt; after writing FRAME_BYTES-1 -> IDLE, so CLEAR lasts exactly FRAME_BYTES cycles.
REQ-019 In PENDING: wr_ready=0; at a frame boundary -> SWAP.
REQ-020 In SWAP: toggle front_sel, assert commit_done for one cycle, then go to IDLE.
REQ-021 A write in the same cycle as an accepted commit SHALL be performed before PENDING is entered.
REQ-022 While wr_ready=0, wr_en, commit and clear SHALL be ignored with no queuing.
REQ-023 The back bank SHALL NOT be copied on swap; the host rewrites or clears it.
REQ-024 A boundary occurring while not PENDING SHALL produce only frame_tick.

Reset
REQ-025 When rst_n=0 at a clock edge: state=IDLE, front_sel=0, clr_cnt=0, wr_ready=1 from the next cycle, commit_done=0 and frame_tick=0.
REQ-026 Bank contents SHALL NOT be reset.
REQ-027 Reset during CLEAR or PENDING SHALL abort the operation with no swap.

Configuration
REQ-028 With macro EVERLOOP_DIM_EN defined: add input brightness[7:0], and led_data = (byte * (brightness+1)) >> 8, still combinational; brightness=255 SHALL pass bytes unchanged.
REQ-029 Without EVERLOOP_DIM_EN defined: no brightness port, and led_data equals the stored byte.

Structure
REQ-030 Package everloop_pkg SHALL hold the FSM state enum and the FRAME_BYTES default constant.
REQ-031 The banks SHALL be sub-module everloop_fbuf: 2 x FRAME_BYTES x 8, one synchronous write port, one asynchronous read port, bank-select inputs.
REQ-032 The FSM, boundary detect and dimming SHALL reside in everloop_fb_ctrl.

Verification
REQ-033 Reset, write 0xAA to address 5, commit, then drive led_addr to 141 -> commit_done pulses one cycle after SWAP; led_addr=5 reads 0xAA; previous front becomes back.
REQ-034 clear in IDLE -> wr_ready low for exactly 141 cycles; after a swap, addresses 0..140 all read 0.
REQ-035 commit and clear in the same cycle -> CLEAR entered, no PENDING; a later boundary produces frame_tick without commit_done.
REQ-036 wr_en with wr_addr=141 or 255, and led_addr=200 -> no bank change; led_data=0.
REQ-037 rst_n low while PENDING, then a boundary -> no swap, front_sel=0, wr_ready=1.
REQ-038 With EVERLOOP_DIM_EN and byte 0x80 -> brightness 255 gives 0x80, 127 gives 0x40, 0 gives 0x00.

Source files
------------

// File: rtl/everloop_pkg.sv
// Shared types and constants for the Everloop LED frame-buffer controller.
package everloop_pkg;

  localparam int unsigned FRAME_BYTES_DEF = 141;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CLEAR   = 2'd1,
    PENDING = 2'd2,
    SWAP    = 2'd3
  } fb_state_t;

endpackage

// File: rtl/everloop_fbuf.sv
// Double-banked LED byte store: one synchronous write port, one asynchronous read port.
module everloop_fbuf
  import everloop_pkg::*;
#(
  parameter int unsigned FRAME_BYTES = FRAME_BYTES_DEF
) (
  input  logic       clk,
  input  logic       i_we,
  input  logic       i_wsel,
  input  logic [7:0] i_waddr,
  input  logic [7:0] i_wdata,
  input  logic       i_rsel,
  input  logic [7:0] i_raddr,
  output logic [7:0] o_rdata_c
);

  localparam int unsigned AW = $clog2(FRAME_BYTES);

  logic [7:0] r_mem [2][FRAME_BYTES];

  always_ff @(posedge clk) begin
    if (i_we && (32'(i_waddr) < FRAME_BYTES)) begin
      r_mem[i_wsel][AW'(i_waddr)] <= i_wdata;
    end
  end

  // Addresses past the frame read as zero rather than aliasing into the bank.
  assign o_rdata_c = (32'(i_raddr) < FRAME_BYTES) ? r_mem[i_rsel][AW'(i_raddr)] : 8'h00;

endmodule

// File: rtl/everloop_fb_ctrl.sv
// Everloop frame-buffer controller: host writes/clears the back bank, swaps at frame boundaries.
// Optional EVERLOOP_DIM_EN adds a brightness input that scales led_data.
module everloop_fb_ctrl
  import everloop_pkg::*;
#(
  parameter int unsigned FRAME_BYTES = FRAME_BYTES_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wr_en,
  input  logic [7:0] wr_addr,
  input  logic [7:0] wr_data,
  output logic       wr_ready,
  input  logic       commit,
  input  logic       clear,
  output logic       commit_done,
  output logic       frame_tick,
  input  logic [7:0] led_addr,
`ifdef EVERLOOP_DIM_EN
  input  logic [7:0] brightness,
`endif
  output logic [7:0] led_data
);

  fb_state_t  r_state;
  fb_state_t  w_state_nxt;
  logic       r_front_sel;
  logic       w_front_nxt;
  logic [7:0] r_clr_cnt;
  logic [7:0] w_clr_cnt_nxt;
  logic       r_wr_ready;
  logic       r_commit_done;
  logic       r_frame_tick;
  logic       r_prev_ne;
  logic       w_boundary;
  logic       w_we;
  logic [7:0] w_waddr;
  logic [7:0] w_wdata;
  logic [7:0] w_rdata;

  // Boundary: led_addr arrives at FRAME_BYTES after being elsewhere.
  assign w_boundary = (32'(led_addr) == FRAME_BYTES) && r_prev_ne;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      r_front_sel   <= 1'b0;
      r_clr_cnt     <= '0;
      r_wr_ready    <= 1'b1;
      r_commit_done <= 1'b0;
      r_frame_tick  <= 1'b0;
      r_prev_ne     <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_front_sel   <= w_front_nxt;
      r_clr_cnt     <= w_clr_cnt_nxt;
      r_wr_ready    <= (w_state_nxt == IDLE);
      r_commit_done <= (r_state == SWAP);
      r_frame_tick  <= w_boundary;
      r_prev_ne     <= (32'(led_addr) != FRAME_BYTES);
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_front_nxt   = r_front_sel;
    w_clr_cnt_nxt = r_clr_cnt;
    w_we          = 1'b0;
    w_waddr       = wr_addr;
    w_wdata       = wr_data;
    case (r_state)
      IDLE: begin
        w_we = wr_en && (32'(wr_addr) < FRAME_BYTES);
        // Clear wins over a simultaneous commit; the commit is dropped.
        if (clear) begin
          w_state_nxt   = CLEAR;
          w_clr_cnt_nxt = '0;
        end else if (commit) begin
          w_state_nxt = PENDING;
        end
      end
      CLEAR: begin
        w_we          = 1'b1;
        w_waddr       = r_clr_cnt;
        w_wdata       = 8'h00;
        w_clr_cnt_nxt = r_clr_cnt + 8'd1;
        if (32'(r_clr_cnt) == FRAME_BYTES - 1) begin
          w_state_nxt   = IDLE;
          w_clr_cnt_nxt = '0;
        end
      end
      PENDING: begin
        if (w_boundary) begin
          w_state_nxt = SWAP;
        end
      end
      SWAP: begin
        w_front_nxt = ~r_front_sel;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  everloop_fbuf #(
    .FRAME_BYTES (FRAME_BYTES)
  ) u_fbuf (
    .clk       (clk),
    .i_we      (w_we && rst_n),
    .i_wsel    (~r_front_sel),
    .i_waddr   (w_waddr),
    .i_wdata   (w_wdata),
    .i_rsel    (r_front_sel),
    .i_raddr   (led_addr),
    .o_rdata_c (w_rdata)
  );

`ifdef EVERLOOP_DIM_EN
  logic [15:0] w_scaled;
  // brightness+1 makes 255 an exact pass-through after the >>8.
  assign w_scaled = 16'(w_rdata) * (16'(brightness) + 16'd1);
  assign led_data = 8'(w_scaled >> 8);
`else
  assign led_data = w_rdata;
`endif

  assign wr_ready    = r_wr_ready;
  assign commit_done = r_commit_done;
  assign frame_tick  = r_frame_tick;

endmodule

// File: tb/tb_everloop_fb_ctrl.sv
// Self-checking bench for everloop_fb_ctrl: directed table, corner sequences, random vs. model.
module tb_everloop_fb_ctrl;

  localparam int FB = 141;

  logic       clk;
  logic       rst_n;
  logic       wr_en;
  logic [7:0] wr_addr;
  logic [7:0] wr_data;
  logic       wr_ready;
  logic       commit;
  logic       clear;
  logic       commit_done;
  logic       frame_tick;
  logic [7:0] led_addr;
  logic [7:0] led_data;
`ifdef EVERLOOP_DIM_EN
  logic [7:0] brightness;
`endif

  everloop_fb_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .wr_ready    (wr_ready),
    .commit      (commit),
    .clear       (clear),
    .commit_done (commit_done),
    .frame_tick  (frame_tick),
    .led_addr    (led_addr),
`ifdef EVERLOOP_DIM_EN
    .brightness  (brightness),
`endif
    .led_data    (led_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // Behavioural model: bank contents plus "what the controller is busy with".
  logic [7:0] m_bank  [2][FB];
  bit         m_known [2][FB];
  int         m_front;
  int         m_clear_left;
  bit         m_pending;
  bit         m_swapping;
  bit         m_prev_ne;
  bit         m_tick;
  bit         m_done;
  bit         m_ready;

  bit last_ready, last_tick, last_done;
  int tick_cnt = 0;
  int done_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] exp_led(input logic [7:0] a);
    int ai;
    int v;
    ai = int'(a);
    if (ai >= FB) return 8'h00;
    v = int'(m_bank[m_front][ai]);
`ifdef EVERLOOP_DIM_EN
    v = (v * (int'(brightness) + 1)) / 256;
`endif
    return 8'(v);
  endfunction

  task automatic model_reset();
    m_front = 0; m_clear_left = 0; m_pending = 0; m_swapping = 0;
    m_prev_ne = 0; m_tick = 0; m_done = 0; m_ready = 1;
  endtask

  task automatic model_edge();
    bit bnd;
    int back;
    if (!rst_n) begin
      model_reset();
      return;
    end
    bnd  = (int'(led_addr) == FB) && m_prev_ne;
    back = 1 - m_front;
    m_tick = bnd;
    m_done = m_swapping;
    if (m_swapping) begin
      m_front    = back;
      m_swapping = 0;
    end else if (m_pending) begin
      if (bnd) begin
        m_pending  = 0;
        m_swapping = 1;
      end
    end else if (m_clear_left > 0) begin
      m_bank[back][FB - m_clear_left]  = 8'h00;
      m_known[back][FB - m_clear_left] = 1;
      m_clear_left--;
    end else begin
      if (wr_en && int'(wr_addr) < FB) begin
        m_bank[back][int'(wr_addr)]  = wr_data;
        m_known[back][int'(wr_addr)] = 1;
      end
      if (clear) m_clear_left = FB;
      else if (commit) m_pending = 1;
    end
    m_prev_ne = (int'(led_addr) != FB);
    m_ready   = !(m_pending || m_swapping || m_clear_left > 0);
  endtask

  // One clock: compare at the falling edge, advance the model, let the DUT clock.
  task automatic step();
    int ai;
    @(negedge clk);
    chk("wr_ready", 32'(wr_ready), 32'(m_ready));
    chk("frame_tick", 32'(frame_tick), 32'(m_tick));
    chk("commit_done", 32'(commit_done), 32'(m_done));
    ai = int'(led_addr);
    if (ai >= FB || m_known[m_front][ai]) chk("led_data", 32'(led_data), 32'(exp_led(led_addr)));
    last_ready = wr_ready;
    last_tick  = frame_tick;
    last_done  = commit_done;
    if (frame_tick) tick_cnt++;
    if (commit_done) done_cnt++;
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic do_swap(input string tag);
    led_addr = 8'd0; commit = 1'b1; step(); commit = 1'b0;
    step();
    led_addr = 8'(FB); step();
    led_addr = 8'd0; step();
    chk({tag, "_swap_cycle_done"}, 32'(last_done), 32'd0);
    chk({tag, "_swap_cycle_tick"}, 32'(last_tick), 32'd1);
    step();
    chk({tag, "_done_pulse"}, 32'(last_done), 32'd1);
    step();
    chk({tag, "_done_single"}, 32'(last_done), 32'd0);
  endtask

  typedef struct {
    logic [7:0] wa;
    logic [7:0] wd;
    logic [7:0] ra;
    logic [7:0] exp;
  } vec_t;

  vec_t tbl[8];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int lowcnt;
    int d0, t0;

    tbl[0] = '{8'd5,   8'hAA, 8'd5,   8'hAA};
    tbl[1] = '{8'd0,   8'h11, 8'd0,   8'h11};
    tbl[2] = '{8'd140, 8'h7E, 8'd140, 8'h7E};
    tbl[3] = '{8'd141, 8'h55, 8'd141, 8'h00};
    tbl[4] = '{8'd255, 8'h66, 8'd200, 8'h00};
    tbl[5] = '{8'd10,  8'hC3, 8'd10,  8'hC3};
    tbl[6] = '{8'd139, 8'h01, 8'd139, 8'h01};
    tbl[7] = '{8'd1,   8'h00, 8'd1,   8'h00};

    rst_n = 1'b0; wr_en = 1'b0; wr_addr = 8'd0; wr_data = 8'd0;
    commit = 1'b0; clear = 1'b0; led_addr = 8'd0;
`ifdef EVERLOOP_DIM_EN
    brightness = 8'd255;
`endif
    for (int b = 0; b < 2; b++)
      for (int i = 0; i < FB; i++) begin
        m_known[b][i] = 0;
        m_bank[b][i]  = 8'h00;
      end
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    rst_n = 1'b1;

    @(negedge clk);
    chk("reset_wr_ready", 32'(wr_ready), 32'd1);
    chk("reset_frame_tick", 32'(frame_tick), 32'd0);
    chk("reset_commit_done", 32'(commit_done), 32'd0);
    @(posedge clk); #1;

    // Clear holds wr_ready low for exactly one frame's worth of cycles.
    clear = 1'b1; step(); clear = 1'b0;
    lowcnt = 0;
    for (int k = 0; k < 400; k++) begin
      step();
      if (last_ready) break;
      lowcnt++;
    end
    chk("clear_busy_cycles", 32'(lowcnt), 32'(FB));
    do_swap("clr");
    for (int i = 0; i < FB; i++) begin
      led_addr = 8'(i); step();
      if (led_data !== 8'h00) chk("cleared_byte", 32'(led_data), 32'd0);
    end
    n_chk++;
    clear = 1'b1; step(); clear = 1'b0;
    for (int k = 0; k < 400 && !m_ready; k++) step();
    chk("clear2_ready", 32'(wr_ready), 32'd1);

    // Table: write back bank (incl. out-of-range drops), swap, read front.
    for (int i = 0; i < 8; i++) begin
      wr_en = 1'b1; wr_addr = tbl[i].wa; wr_data = tbl[i].wd; step();
    end
    wr_en = 1'b0;
    do_swap("tbl");
    for (int i = 0; i < 8; i++) begin
      led_addr = tbl[i].ra; step();
      chk($sformatf("tbl_rd%0d", i), 32'(led_data), 32'(tbl[i].exp));
    end

    // No copy on swap: old front (zeros) becomes back.
    wr_en = 1'b1; wr_addr = 8'd5; wr_data = 8'h12; step(); wr_en = 1'b0;
    do_swap("nocopy");
    led_addr = 8'd5; step(); chk("nocopy_a5", 32'(led_data), 32'h12);
    led_addr = 8'd0; step(); chk("nocopy_a0", 32'(led_data), 32'h00);

    // Clear and commit together: clear only, later boundary ticks without swap.
    d0 = done_cnt; t0 = tick_cnt;
    commit = 1'b1; clear = 1'b1; step(); commit = 1'b0; clear = 1'b0;
    chk("cc_ready_low", 32'(wr_ready), 32'd0);
    for (int k = 0; k < 400 && !m_ready; k++) step();
    led_addr = 8'(FB); step(); led_addr = 8'd0;
    repeat (4) step();
    chk("cc_no_done", 32'(done_cnt - d0), 32'd0);
    chk("cc_one_tick", 32'(tick_cnt - t0), 32'd1);
    led_addr = 8'd5; step(); chk("cc_front_kept", 32'(led_data), 32'h12);

    // Reset aborts a pending commit.
    rst_n = 1'b0; step(); rst_n = 1'b1;
    led_addr = 8'd0; commit = 1'b1; step(); commit = 1'b0;
    rst_n = 1'b0; step(); rst_n = 1'b1;
    d0 = done_cnt;
    step(); led_addr = 8'(FB); step(); led_addr = 8'd0;
    repeat (4) step();
    chk("rstpend_no_done", 32'(done_cnt - d0), 32'd0);
    chk("rstpend_ready", 32'(wr_ready), 32'd1);
    led_addr = 8'd5; step(); chk("rstpend_front0", 32'(led_data), 32'h00);

`ifdef EVERLOOP_DIM_EN
    wr_en = 1'b1; wr_addr = 8'd50; wr_data = 8'h80; step(); wr_en = 1'b0;
    do_swap("dim");
    led_addr = 8'd50;
    brightness = 8'd255; step(); chk("dim_255", 32'(led_data), 32'h80);
    brightness = 8'd127; step(); chk("dim_127", 32'(led_data), 32'h40);
    brightness = 8'd0;   step(); chk("dim_0",   32'(led_data), 32'h00);
    brightness = 8'd255;
`endif

    // Random traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      rst_n    = ($urandom_range(0, 299) != 0);
      wr_en    = 1'($urandom_range(0, 1));
      wr_addr  = 8'($urandom_range(0, 160));
      wr_data  = 8'($urandom);
      commit   = ($urandom_range(0, 19) == 0);
      clear    = ($urandom_range(0, 99) == 0);
      led_addr = ($urandom_range(0, 7) == 0) ? 8'(FB) : 8'($urandom_range(0, 255));
`ifdef EVERLOOP_DIM_EN
      brightness = 8'($urandom);
`endif
      step();
    end
    rst_n = 1'b1; wr_en = 1'b0; commit = 1'b0; clear = 1'b0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
